// File: rtl/irq_accept_if.sv
// Bus between the interrupt acceptance sequencer, the per-line request cells and the CPU.
// Cells drive sz_/rp and consume ckrp/zerrz_; the CPU drives ien/ack and consumes irq/num.
interface irq_accept_if #(
  parameter int N = 32,
  parameter int W = 5
);
  logic [N-1:0] sz_;
  logic [N-1:0] rp;
  logic         ien;
  logic         ack;
  logic         ckrp;
  logic [N-1:0] zerrz_;
  logic         irq;
  logic [W-1:0] num;
  logic         busy;
  logic [2:0]   dbg_state;

  // Handshake: irq is held high until the CPU raises ack; ack is a level that the CPU
  // keeps high until it sees irq drop, and a new request is never raised while ack is high.
  modport slave (
    input  sz_, rp, ien, ack,
    output ckrp, zerrz_, irq, num, busy, dbg_state
  );

  modport master (
    output sz_, rp, ien, ack,
    input  ckrp, zerrz_, irq, num, busy, dbg_state
  );
endinterface

// File: rtl/irq_accept.sv
// Interrupt acceptance sequencer: strobes the cells' service registers, presents the
// highest-priority latched line to the CPU, and clears that line once it is acknowledged.
module irq_accept #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic          clk_sys,
  input  logic          clm_,
  irq_accept_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STROBE   = 3'd1,
    SELECT   = 3'd2,
    REQ      = 3'd3,
    CLEAR    = 3'd4,
    RESTROBE = 3'd5,
    RELEASE  = 3'd6
  } state_e;

  state_e         state_q, state_d;
  logic           ckrp_q, ckrp_d;
  logic           irq_q, irq_d;
  logic           busy_q, busy_d;
  logic [N-1:0]   zerrz_q, zerrz_d;
  logic [W-1:0]   num_q, num_d;
  logic [W-1:0]   sel;
  logic           found;

  // Fixed priority: scanning downwards lets the lowest set index overwrite last.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.rp[i]) begin
        found = 1'b1;
        sel   = W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    unique case (state_q)
      IDLE:     if (bus.ien && !(&bus.sz_)) state_d = STROBE;
      STROBE:   state_d = SELECT;
      SELECT: begin
        if (found) begin
          state_d = REQ;
          num_d   = sel;
        end else begin
          state_d = IDLE;
        end
      end
      // ack takes precedence over a simultaneous drop of ien.
      REQ: begin
        if (bus.ack)       state_d = CLEAR;
        else if (!bus.ien) state_d = IDLE;
      end
      CLEAR:    state_d = RESTROBE;
      RESTROBE: state_d = RELEASE;
      RELEASE:  if (!bus.ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered alongside it.
    ckrp_d  = (state_d == STROBE) || (state_d == RESTROBE);
    irq_d   = (state_d == REQ) || (state_d == CLEAR) || (state_d == RESTROBE);
    busy_d  = (state_d != IDLE);
    zerrz_d = '1;
    if (state_d == CLEAR) zerrz_d[num_q] = 1'b0;
  end

  always_ff @(posedge clk_sys or negedge clm_) begin
    if (!clm_) begin
      state_q <= IDLE;
      ckrp_q  <= 1'b0;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
      zerrz_q <= '1;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      ckrp_q  <= ckrp_d;
      irq_q   <= irq_d;
      busy_q  <= busy_d;
      zerrz_q <= zerrz_d;
      num_q   <= num_d;
    end
  end

  assign bus.ckrp      = ckrp_q;
  assign bus.irq       = irq_q;
  assign bus.busy      = busy_q;
  assign bus.zerrz_    = zerrz_q;
  assign bus.num       = num_q;
  assign bus.dbg_state = state_q;

endmodule
